// File: rtl/cnt_obi_regs.sv
// Free-running up-counter with threshold wrap and a 4-register OBI window; level terminal-count interrupt.
// Latency: rvalid/rdata one cycle after gnt. Backpressure: none, gnt = req every cycle.
package cnt_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module cnt_obi_regs
    import cnt_obi_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  obi_req_t         bus_req_i,
    output obi_resp_t        bus_rsp_o,
    output logic             tc_int_o,
    output logic [CNT_W-1:0] cnt_value_o
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_THRESH = 2'd1,
        REG_VALUE  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic             en_q, en_d;
    logic             ie_q, ie_d;
    logic             tc_q, tc_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [CNT_W-1:0] value_q, value_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr_en;
    logic             rd_en;
    reg_sel_e         sel;
    logic             clr;
    logic             terminal;
    logic             tc_set;
    logic [31:0]      rd_mux;
    logic             unused_addr_bits;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign wr_en            = bus_req_i.req & bus_req_i.we;
    assign rd_en            = bus_req_i.req & ~bus_req_i.we;
    assign sel              = reg_sel_e'(bus_req_i.addr[3:2]);
    assign terminal         = en_q && (value_q == thresh_q);
    assign unused_addr_bits = ^{bus_req_i.addr[31:4], bus_req_i.addr[1:0]};

    always_comb begin
        rd_mux = 32'd0;
        unique case (sel)
            REG_CTRL:   rd_mux = {29'd0, ie_q, 1'b0, en_q};
            REG_THRESH: rd_mux = 32'(thresh_q);
            REG_VALUE:  rd_mux = 32'(value_q);
            REG_STATUS: rd_mux = {31'd0, tc_q};
            default:    rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        ie_d     = ie_q;
        thresh_d = thresh_q;
        value_d  = value_q;
        tc_d     = tc_q;
        clr      = 1'b0;
        tc_set   = 1'b0;

        if (wr_en && sel == REG_CTRL && bus_req_i.be[0]) begin
            en_d = bus_req_i.wdata[0];
            clr  = bus_req_i.wdata[1];
            ie_d = bus_req_i.wdata[2];
        end

        if (wr_en && sel == REG_THRESH) begin
            thresh_d = CNT_W'(be_merge(32'(thresh_q), bus_req_i.wdata, bus_req_i.be));
        end

        // Bus write beats CLR beats counting; TC only fires when the count step is taken.
        if (wr_en && sel == REG_VALUE) begin
            value_d = CNT_W'(be_merge(32'(value_q), bus_req_i.wdata, bus_req_i.be));
        end else if (clr) begin
            value_d = '0;
        end else if (en_q) begin
            value_d = terminal ? '0 : value_q + CNT_W'(1);
            tc_set  = terminal;
        end

        if (wr_en && sel == REG_STATUS && bus_req_i.be[0] && bus_req_i.wdata[0]) begin
            tc_d = 1'b0;
        end
        if (tc_set) begin
            tc_d = 1'b1;
        end

        rvalid_d = bus_req_i.req;
        rdata_d  = rd_en ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            tc_q     <= 1'b0;
            thresh_q <= '0;
            value_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            en_q     <= en_d;
            ie_q     <= ie_d;
            tc_q     <= tc_d;
            thresh_q <= thresh_d;
            value_q  <= value_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_rsp_o.gnt    = bus_req_i.req;
    assign bus_rsp_o.rvalid = rvalid_q;
    assign bus_rsp_o.rdata  = rdata_q;
    assign tc_int_o         = tc_q & ie_q;
    assign cnt_value_o      = value_q;

endmodule

// File: tb/tb_cnt_obi_regs.sv
// Directed bench for cnt_obi_regs: register map, counting, W1C/priority corners, back-to-back reads, reset.
module tb_cnt_obi_regs;
    import cnt_obi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    obi_req_t    req_s;
    obi_resp_t   rsp_s;
    logic        tc_int;
    logic [31:0] cnt_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cnt_obi_regs #(.CNT_W(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus_req_i   (req_s),
        .bus_rsp_o   (rsp_s),
        .tc_int_o    (tc_int),
        .cnt_value_o (cnt_val)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        req_s.req   = r;
        req_s.we    = w;
        req_s.addr  = a;
        req_s.wdata = d;
        req_s.be    = be;
    endtask

    // Called at a falling edge; returns at the falling edge after the response.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        drive(1'b1, 1'b1, a, d, be);
        #1 check_eq("wr_gnt", 32'(rsp_s.gnt), 32'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        check_eq("wr_rvalid", 32'(rsp_s.rvalid), 32'd1);
        check_eq("wr_rdata", rsp_s.rdata, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'd0, 4'h0);
        #1 check_eq("rd_gnt", 32'(rsp_s.gnt), 32'd1);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        check_eq("rd_rvalid", 32'(rsp_s.rvalid), 32'd1);
        check_eq(tag, rsp_s.rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        #3;
        check_eq("rst_rvalid", 32'(rsp_s.rvalid), 32'd0);
        check_eq("rst_rdata", rsp_s.rdata, 32'd0);
        check_eq("rst_tc_int", 32'(tc_int), 32'd0);
        check_eq("rst_cnt", cnt_val, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        check_eq("idle_gnt", 32'(rsp_s.gnt), 32'd0);

        rd("rst_ctrl",   32'h0, 32'd0);
        rd("rst_thresh", 32'h4, 32'd0);
        rd("rst_value",  32'h8, 32'd0);
        rd("rst_status", 32'hC, 32'd0);

        // Count 0..3 then wrap with TC
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h5);
        check_eq("cnt_0", cnt_val, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_i);
            check_eq("cnt_step", cnt_val, 32'(i));
        end
        check_eq("tc_int_pre", 32'(tc_int), 32'd0);
        @(negedge clk_i);
        check_eq("cnt_wrap", cnt_val, 32'd0);
        check_eq("tc_int_set", 32'(tc_int), 32'd1);
        wr(32'hC, 32'd1);
        check_eq("tc_int_clr", 32'(tc_int), 32'd0);
        wr(32'h0, 32'h0);

        // Byte enables, CTRL readback, address aliasing
        wr(32'h8, 32'd0);
        wr(32'h8, 32'hAABBCCDD, 4'b0101);
        rd("be_value", 32'h8, 32'h00BB00DD);
        wr(32'h0, 32'hFFFFFFF4);
        rd("ctrl_rb", 32'h0, 32'h4);
        wr(32'h0, 32'h0);
        rd("alias_thresh", 32'h10000015, 32'd3);

        // Terminal count coincident with TC W1C
        wr(32'h4, 32'd5);
        wr(32'h8, 32'd5);
        wr(32'h0, 32'h1);
        wr(32'hC, 32'd1);
        check_eq("coll_value", cnt_val, 32'd0);
        rd("coll_tc", 32'hC, 32'd1);
        wr(32'h0, 32'h0);

        // CLR, VALUE write after CLR, CLR together with EN
        wr(32'h0, 32'h2);
        check_eq("clr_value", cnt_val, 32'd0);
        wr(32'h8, 32'd7);
        rd("wr_after_clr", 32'h8, 32'd7);
        wr(32'h0, 32'h3);
        check_eq("clr_en_0", cnt_val, 32'd0);
        @(negedge clk_i);
        check_eq("clr_en_1", cnt_val, 32'd1);
        wr(32'h0, 32'h0);

        // THRESH below VALUE: run to all-ones and wrap without TC
        wr(32'hC, 32'd1);
        wr(32'h4, 32'd5);
        wr(32'h8, 32'hFFFFFFFE);
        wr(32'h0, 32'h1);
        check_eq("hi_fe", cnt_val, 32'hFFFFFFFE);
        @(negedge clk_i);
        check_eq("hi_ff", cnt_val, 32'hFFFFFFFF);
        @(negedge clk_i);
        check_eq("hi_wrap", cnt_val, 32'd0);
        rd("hi_no_tc", 32'hC, 32'd0);
        wr(32'h0, 32'h0);

        // THRESH=0: stays 0, TC every cycle, set beats W1C
        wr(32'h4, 32'd0);
        wr(32'h8, 32'd0);
        wr(32'h0, 32'h5);
        check_eq("t0_tc_int_0", 32'(tc_int), 32'd0);
        @(negedge clk_i);
        check_eq("t0_value", cnt_val, 32'd0);
        check_eq("t0_tc_int_1", 32'(tc_int), 32'd1);
        wr(32'hC, 32'd1);
        check_eq("t0_set_wins", 32'(tc_int), 32'd1);
        wr(32'h0, 32'h0);

        // Back-to-back reads snapshot the counter
        wr(32'h8, 32'd10);
        wr(32'h0, 32'h1);
        check_eq("b2b_start", cnt_val, 32'd10);
        drive(1'b1, 1'b0, 32'h8, 32'd0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("b2b_rvalid", 32'(rsp_s.rvalid), 32'd1);
            check_eq("b2b_rdata", rsp_s.rdata, 32'(10 + k));
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk_i);
        check_eq("b2b_end_rvalid", 32'(rsp_s.rvalid), 32'd0);
        check_eq("b2b_end_rdata", rsp_s.rdata, 32'd0);

        // Reset with a read outstanding
        wr(32'h4, 32'd9);
        wr(32'h0, 32'h5);
        drive(1'b1, 1'b0, 32'h8, 32'd0, 4'h0);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_gnt", 32'(rsp_s.gnt), 32'd1);
        check_eq("mid_rst_rvalid", 32'(rsp_s.rvalid), 32'd0);
        check_eq("mid_rst_cnt", cnt_val, 32'd0);
        check_eq("mid_rst_tc_int", 32'(tc_int), 32'd0);
        @(negedge clk_i);
        check_eq("in_rst_rvalid", 32'(rsp_s.rvalid), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_eq("rel_rvalid", 32'(rsp_s.rvalid), 32'd0);
        rd("post_value",  32'h8, 32'd0);
        rd("post_ctrl",   32'h0, 32'd0);
        rd("post_thresh", 32'h4, 32'd0);
        rd("post_status", 32'hC, 32'd0);
        check_eq("post_cnt", cnt_val, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_obi_regs.md
CNT_OBI_REGS -- requirements
Module: cnt_obi_regs

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, which sets the counter and threshold width (1..32).
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port bus_req_i, input, cnt_obi_pkg::obi_req_t: OBI request (req, we, be[3:0], addr[31:0], wdata[31:0]).
REQ-005 The block SHALL have port bus_rsp_o, output, cnt_obi_pkg::obi_resp_t: OBI response (gnt, rvalid, rdata[31:0]).
REQ-006 The block SHALL have port tc_int_o, output, 1 bit: terminal-count interrupt, level.
REQ-007 The block SHALL have port cnt_value_o, output, CNT_W bits: live counter value.

Function
REQ-008 The register map SHALL be decoded on addr[3:2] only, with addr[31:4] and addr[1:0] ignored: 0x0 CTRL, 0x4 THRESH, 0x8 VALUE, 0xC STATUS.
REQ-009 The CTRL fields SHALL be: bit0 EN (RW); bit1 CLR (write-1 pulse, reads 0); bit2 IE (RW); all other bits read 0.
REQ-010 THRESH and VALUE SHALL be RW and CNT_W wide; upper unused bits read 0 and ignore writes.
REQ-011 STATUS SHALL provide bit0 TC: sticky, write-1-to-clear, other bits read 0.
REQ-012 Writes SHALL honour be[3:0] per byte; a byte with be=0 leaves the corresponding register byte unchanged.
REQ-013 bus_rsp_o.gnt SHALL equal bus_req_i.req combinationally; every request is granted in the same cycle, with no stalls.
REQ-014 bus_rsp_o.rvalid SHALL assert exactly one cycle after each granted request, for both reads and writes; at most one response per cycle.
REQ-015 For a read, rdata SHALL carry the register value as it was in the grant cycle, before that edge's update; for a write, rdata SHALL be 0; when rvalid=0, rdata SHALL be 0.
REQ-016 Back-to-back requests on consecutive cycles SHALL produce rvalid on consecutive cycles with no bubble.
REQ-017 Counter step: when EN=1 and VALUE != THRESH, VALUE <= VALUE+1.
REQ-018 Terminal count: when EN=1 and VALUE == THRESH, VALUE <= 0 and TC <= 1 on the same edge.
REQ-019 When THRESH=0 and EN=1, VALUE SHALL stay 0 and TC SHALL be set every cycle.
REQ-020 When EN=0, VALUE SHALL hold.
REQ-021 VALUE update priority SHALL be: bus write to VALUE > CLR=1 (VALUE <= 0) > counting.
REQ-022 A CLR write with EN=1 in the same write SHALL leave VALUE=0 after the edge, with counting resuming on the next cycle.
REQ-023 A terminal-count event and a W1C of TC in the same cycle SHALL leave TC=1 (set wins).
REQ-024 A THRESH write lowering THRESH below the current VALUE SHALL NOT cause an immediate wrap; the counter counts up to 2^CNT_W-1 and wraps to 0 without setting TC, then continues normally.
REQ-025 A THRESH write SHALL take effect for the compare on the cycle after the write edge.
REQ-026 tc_int_o SHALL equal TC & IE, both registered, with no combinational path from bus_req_i.
REQ-027 cnt_value_o SHALL equal the VALUE register.

Reset
REQ-028 On rst_ni=0, asynchronously: CTRL=0, THRESH=0, VALUE=0, TC=0, the rvalid flop=0, and rdata=0; therefore tc_int_o=0 and cnt_value_o=0.
REQ-029 Reset asserted mid-transaction SHALL drop the pending rvalid; no response is issued after reset release.
REQ-030 After rst_ni rises, the first granted request SHALL behave per REQ-013 to REQ-016 with no extra latency.

Verification
REQ-031 Reset/readback: after reset, read 0x0/0x4/0x8/0xC -> rvalid one cycle after each, rdata=0 for all four; gnt=req every cycle.
REQ-032 Count and terminal count: write THRESH=3, then CTRL=0x5 -> VALUE goes 0,1,2,3,0; TC=1 and tc_int_o=1 in the cycle after the 3->0 edge; write STATUS=1 -> tc_int_o=0 next cycle.
REQ-033 Byte enables: VALUE=0x00000000, EN=0; write 0xAABBCCDD with be=0b0101 -> read VALUE returns 0x00BB00DD.
REQ-034 Priority and collision: EN=1, THRESH=5, VALUE=5; in one cycle write STATUS=1 -> TC=1 and VALUE=0; separately, a write of VALUE=7 coincident with CLR -> VALUE=7.
REQ-035 Back-to-back and read snapshot: EN=1 and VALUE=10; issue reads of VALUE on 3 consecutive cycles -> 3 consecutive rvalids returning 10, 11, 12.
REQ-036 Reset mid-operation: issue a read, assert rst_ni=0 before rvalid -> no rvalid, all registers 0; after release, the first read returns 0.
